// File: rtl/mawg_multi.sv
// Multi-channel arbitrary waveform generator: per-channel phase accumulators
// with shadow/live config, frequency sweep, selectable output and a full mix.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_we/ch/addr    shadow register write (0 freq, 1 duty, 2 mode,
//   cfg_data            3 sweep_inc, 4 sweep_max; other addresses ignored)
//   commit            copy every shadow register to its live register
//   out_sel           channel routed to signal (0 when out of range)
//   signal            registered sample of the selected channel
//   mix               registered unsigned sum of all channel samples
//   sweep_done        one-cycle pulse per channel when its sweep restarts
module mawg_multi #(
   parameter int NUM_CH  = 4,
   parameter int PHASE_W = 32,
   parameter int DATA_W  = 8,
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_we,
   input  logic [CW-1:0]        cfg_ch,
   input  logic [2:0]           cfg_addr,
   input  logic [PHASE_W-1:0]   cfg_data,
   input  logic                 commit,
   input  logic [CW-1:0]        out_sel,
   output logic [DATA_W-1:0]    signal,
   output logic [DATA_W+CW-1:0] mix,
   output logic [NUM_CH-1:0]    sweep_done
);

   logic [DATA_W-1:0] smp [NUM_CH];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [PHASE_W-1:0] sh_freq, sh_duty, sh_inc, sh_max;
      logic [4:0]         sh_mode;
      logic [PHASE_W-1:0] base_freq, cur_freq;
      logic [PHASE_W-1:0] lv_duty, lv_inc, lv_max;
      logic [1:0]         lv_wave;
      logic               lv_en, lv_sweep;
      logic [PHASE_W-1:0] phase;
      logic [PHASE_W:0]   ph_sum, sw_sum;
      logic               wr, wrap, sw_over;
      logic [DATA_W-1:0]  p, tri_w, smp_d, smp_q;
      logic               done_q;

      assign wr      = cfg_we && (cfg_ch == CW'(c));
      assign ph_sum  = {1'b0, phase} + {1'b0, cur_freq};
      // Carry only counts while the accumulator actually advances.
      assign wrap    = lv_en && ph_sum[PHASE_W];
      assign sw_sum  = {1'b0, cur_freq} + {1'b0, lv_inc};
      assign sw_over = sw_sum[PHASE_W] || (sw_sum[PHASE_W-1:0] > lv_max);
      assign p       = phase[PHASE_W-1 -: DATA_W];
      assign tri_w   = {p[DATA_W-2:0], 1'b0};

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sh_freq <= '0;
            sh_duty <= '0;
            sh_mode <= '0;
            sh_inc  <= '0;
            sh_max  <= '0;
         end else if (wr) begin
            case (cfg_addr)
               3'd0:    sh_freq <= cfg_data;
               3'd1:    sh_duty <= cfg_data;
               3'd2:    sh_mode <= cfg_data[4:0];
               3'd3:    sh_inc  <= cfg_data;
               3'd4:    sh_max  <= cfg_data;
               default: ;
            endcase
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            base_freq <= '0;
            lv_duty   <= '0;
            lv_inc    <= '0;
            lv_max    <= '0;
            lv_wave   <= '0;
            lv_en     <= 1'b0;
            lv_sweep  <= 1'b0;
         end else if (commit) begin
            base_freq <= sh_freq;
            lv_duty   <= sh_duty;
            lv_inc    <= sh_inc;
            lv_max    <= sh_max;
            lv_wave   <= sh_mode[1:0];
            lv_en     <= sh_mode[2];
            lv_sweep  <= sh_mode[4];
         end
      end

      // Phase and the sweeping frequency; commit overrides any sweep step.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            phase    <= '0;
            cur_freq <= '0;
            done_q   <= 1'b0;
         end else begin
            done_q <= 1'b0;
            if (commit && sh_mode[3])
               phase <= '0;
            else if (lv_en)
               phase <= ph_sum[PHASE_W-1:0];
            if (commit) begin
               cur_freq <= sh_freq;
            end else if (wrap && lv_sweep) begin
               if (sw_over) begin
                  cur_freq <= base_freq;
                  done_q   <= 1'b1;
               end else begin
                  cur_freq <= sw_sum[PHASE_W-1:0];
               end
            end
         end
      end

      always_comb begin
         smp_d = '0;
         if (lv_en) begin
            case (lv_wave)
               2'b00:   smp_d = p;
               2'b01:   smp_d = (phase < lv_duty) ? {DATA_W{1'b1}} : '0;
               2'b10:   smp_d = p[DATA_W-1] ? ~tri_w : tri_w;
               default: smp_d = '0;
            endcase
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            smp_q <= '0;
         else
            smp_q <= smp_d;
      end

      assign smp[c]        = smp_q;
      assign sweep_done[c] = done_q;
   end

   logic [DATA_W-1:0]    sel_d;
   logic [DATA_W+CW-1:0] mix_d;

   // Loop compare leaves sel_d at 0 for an out-of-range out_sel.
   always_comb begin
      sel_d = '0;
      mix_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (out_sel == CW'(i))
            sel_d = smp[i];
         mix_d = mix_d + (DATA_W+CW)'(smp[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         signal <= '0;
         mix    <= '0;
      end else begin
         signal <= sel_d;
         mix    <= mix_d;
      end
   end

endmodule

// File: tb/tb_mawg_multi.sv
// Scoreboard bench for mawg_multi: stimulus queues expected outputs
// tagged with a cycle number, a negedge monitor pops and compares.
module tb_mawg_multi;
   localparam int NUM_CH  = 4;
   localparam int PHASE_W = 32;
   localparam int DATA_W  = 8;
   localparam int CW      = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 cfg_we = 1'b0;
   logic [CW-1:0]        cfg_ch = '0;
   logic [2:0]           cfg_addr = '0;
   logic [PHASE_W-1:0]   cfg_data = '0;
   logic                 commit = 1'b0;
   logic [CW-1:0]        out_sel = '0;
   logic [DATA_W-1:0]    signal;
   logic [DATA_W+CW-1:0] mix;
   logic [NUM_CH-1:0]    sweep_done;

   mawg_multi #(
      .NUM_CH(NUM_CH), .PHASE_W(PHASE_W), .DATA_W(DATA_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .commit(commit),
      .out_sel(out_sel), .signal(signal), .mix(mix),
      .sweep_done(sweep_done)
   );

   typedef struct {
      int          tag;
      int          kind;
      int unsigned exp;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_run = 0;
   int   n_fail = 0;

   // Hand-derived ch2 sweep trace (signal from k=2, sweep_done from k=1).
   int unsigned d_sig [13] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00, 8'h80,
                               8'h00, 8'h40, 8'h80, 8'hC0, 8'h00, 8'h80,
                               8'h00};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int unsigned act_of(input int kind);
      case (kind)
         0:       return 32'(signal);
         1:       return 32'(mix);
         default: return 32'(sweep_done);
      endcase
   endfunction

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].tag < cyc) begin
            n_run++;
            n_fail++;
            $display("FAIL %s tag=%0d not checked in time", sb[i].name,
                     sb[i].tag);
            sb.delete(i);
         end else if (sb[i].tag == cyc) begin
            n_run++;
            if (act_of(sb[i].kind) !== sb[i].exp) begin
               n_fail++;
               $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h",
                        sb[i].name, cyc, act_of(sb[i].kind), sb[i].exp);
            end
            sb.delete(i);
         end
      end
   end

   task automatic push(input int tag, input int kind, input int unsigned e,
                       input string nm);
      exp_t x;
      x.tag  = tag;
      x.kind = kind;
      x.exp  = e;
      x.name = nm;
      sb.push_back(x);
   endtask

   task automatic wr(input int ch, input int a, input logic [31:0] d);
      cfg_we   = 1'b1;
      cfg_ch   = CW'(ch);
      cfg_addr = 3'(a);
      cfg_data = d;
      @(negedge clk);
      cfg_we   = 1'b0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   initial begin
      int n, m, c0, kc, j, ph, guard;

      // Reset state
      for (int t = 1; t <= 2; t++) begin
         push(t, 0, 0, "rst_signal");
         push(t, 1, 0, "rst_mix");
         push(t, 2, 0, "rst_done");
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // ch0 saw ramp, +1 per cycle, wraps 0xFF -> 0x00
      wr(0, 0, 32'h0100_0000);
      wr(0, 2, 32'h04);
      out_sel = 2'd0;
      n = cyc;
      commit = 1'b1;
      for (int k = 2; k <= 262; k++)
         push(n + 1 + k, 0, (k - 2) % 256, "saw_ramp");
      @(negedge clk);
      commit = 1'b0;

      // Shadow freq rewrite: no change until the commit edge kc
      wait_until(n + 1 + 262);
      c0 = cyc;
      kc = c0 + 4 - n;
      for (int k = c0 - n; k <= c0 - n + 19; k++) begin
         j  = k - 2;
         ph = (j <= kc) ? j : kc + 2 * (j - kc);
         push(n + 1 + k, 0, ph % 256, "freq_commit");
      end
      wr(0, 0, 32'h0200_0000);
      wait_until(c0 + 4);
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
      wait_until(c0 + 21);

      // ch1 square: 16 x 0xFF then 48 x 0x00
      wr(1, 0, 32'h0400_0000);
      wr(1, 1, 32'h4000_0000);
      wr(1, 2, 32'h05);
      out_sel = 2'd1;
      m = cyc;
      commit = 1'b1;
      for (int k = 2; k <= 133; k++)
         push(m + 1 + k, 0, (((k - 2) % 64) < 16) ? 32'hFF : 32'h0,
              "square");
      @(negedge clk);
      commit = 1'b0;
      wait_until(m + 1 + 133);

      // ch2 sweep 0x4.. -> 0x8.. -> reload with sweep_done[2]
      wr(2, 0, 32'h4000_0000);
      wr(2, 3, 32'h4000_0000);
      wr(2, 4, 32'h8000_0000);
      wr(2, 2, 32'h14);
      out_sel = 2'd2;
      m = cyc;
      commit = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         push(m + 1 + k, 2, (k == 6 || k == 12) ? 32'h4 : 32'h0,
              "sweep_done");
         if (k >= 2)
            push(m + 1 + k, 0, d_sig[k - 2], "sweep_sig");
      end
      @(negedge clk);
      commit = 1'b0;
      wait_until(m + 15);

      // All channels saw, same freq, phase reset on commit
      for (int ch = 0; ch < NUM_CH; ch++) begin
         wr(ch, 0, 32'h0100_0000);
         wr(ch, 2, 32'h0C);
      end
      out_sel = 2'd0;
      m = cyc;
      commit = 1'b1;
      for (int k = 2; k <= 265; k++) begin
         push(m + 1 + k, 0, (k - 2) % 256, "mix_sig");
         push(m + 1 + k, 1, 4 * ((k - 2) % 256), "mix_sum");
      end
      @(negedge clk);
      commit = 1'b0;
      wait_until(m + 1 + 265);

      // Mid-run reset clears outputs before the next edge
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      push(cyc, 0, 0, "midrst_signal");
      push(cyc, 1, 0, "midrst_mix");
      push(cyc, 2, 0, "midrst_done");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Cleared shadow freq and ignored addresses keep ch0 silent
      wr(0, 2, 32'h04);
      wr(0, 4, 32'h0100_0000);
      wr(0, 5, 32'h0100_0000);
      wr(0, 6, 32'h0100_0000);
      wr(0, 7, 32'h0100_0000);
      out_sel = 2'd0;
      m = cyc;
      commit = 1'b1;
      for (int k = 2; k <= 20; k++) begin
         push(m + 1 + k, 0, 0, "post_rst_sig");
         push(m + 1 + k, 1, 0, "post_rst_mix");
      end
      @(negedge clk);
      commit = 1'b0;
      wait_until(m + 21);

      guard = 0;
      while (sb.size() != 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) begin
         n_run++;
         n_fail++;
         $display("FAIL sb_drain left=%0d required=0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
